jogador_automatico: RTL and testbench

JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

---
 rtl/jogador_pkg.sv | 35 +++
 rtl/rom_jogadas_16x4.sv | 36 +++
 rtl/jogador_automatico.sv | 156 +++++++++++++++
 tb/tb_jogador_automatico.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogador_pkg.sv
// jogador_pkg
// Shared definitions for the automatic player: FSM state encoding (matches
// the values shown on the hex display), default timing constants, ROM depth
// and a helper that sizes the single phase timer.
package jogador_pkg;

    typedef enum logic [2:0] {
        INICIAL       = 3'd0,
        ESPERA_RODADA = 3'd1,
        PRESSIONA     = 3'd2,
        SOLTA         = 3'd3,
        FIM           = 3'd4
    } estado_t;

    localparam int T_ESPERA_PADRAO  = 5;
    localparam int T_PRESS_PADRAO   = 5;
    localparam int T_SOLTA_PADRAO   = 5;
    localparam int N_RODADAS_PADRAO = 16;
    localparam int ROM_PROF         = 16;

    // Bits needed to count 0 .. max(a,b,c)-1 (at least 1 bit).
    function automatic int unsigned largura_timer(input int unsigned a,
                                                  input int unsigned b,
                                                  input int unsigned c);
        int unsigned m;
        int unsigned w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = 1;
        while ((32'd1 << w) < m) w++;
        return w;
    endfunction

endpackage

// File: rtl/rom_jogadas_16x4.sv
// rom_jogadas_16x4
// Fixed sequence of one-hot plays used by the automatic player.
// Ports:
//   i_endereco  in  4  play index
//   o_dado      out 4  one-hot play at that index (combinational)
module rom_jogadas_16x4
    import jogador_pkg::*;
(
    input  logic [$clog2(ROM_PROF)-1:0] i_endereco,
    output logic [3:0]                  o_dado
);

    always_comb begin
        o_dado = 4'h1;
        case (i_endereco)
            4'd0:  o_dado = 4'h1;
            4'd1:  o_dado = 4'h2;
            4'd2:  o_dado = 4'h4;
            4'd3:  o_dado = 4'h8;
            4'd4:  o_dado = 4'h4;
            4'd5:  o_dado = 4'h2;
            4'd6:  o_dado = 4'h1;
            4'd7:  o_dado = 4'h1;
            4'd8:  o_dado = 4'h2;
            4'd9:  o_dado = 4'h2;
            4'd10: o_dado = 4'h4;
            4'd11: o_dado = 4'h4;
            4'd12: o_dado = 4'h8;
            4'd13: o_dado = 4'h8;
            4'd14: o_dado = 4'h1;
            4'd15: o_dado = 4'h4;
            default: o_dado = 4'h1;
        endcase
    end

endmodule

// File: rtl/jogador_automatico.sv
// jogador_automatico
// Automatic player that drives a memory game's chaves input: round r plays
// rom[0..r], each play held T_PRESS cycles followed by T_SOLTA idle cycles,
// with T_ESPERA idle cycles before every round. Optionally injects one wrong
// play (ROM value rotated left by one bit).
// Ports:
//   clock, reset              clock; asynchronous active-high reset
//   iniciar                   start/restart (only in INICIAL and FIM)
//   parar                     abort to FIM from any busy state
//   forca_erro                enable error injection
//   erro_rodada, erro_jogada  round/play index of the injected error
//   chaves                    one-hot play, 0 when idle
//   ocupado                   high in ESPERA_RODADA, PRESSIONA, SOLTA
//   fim_jogadas               high in FIM
//   db_rodada, db_jogada      current round / play index
//   db_estado                 state encoding
module jogador_automatico
    import jogador_pkg::*;
#(
    parameter int T_ESPERA  = T_ESPERA_PADRAO,
    parameter int T_PRESS   = T_PRESS_PADRAO,
    parameter int T_SOLTA   = T_SOLTA_PADRAO,
    parameter int N_RODADAS = N_RODADAS_PADRAO
)
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       parar,
    input  logic       forca_erro,
    input  logic [3:0] erro_rodada,
    input  logic [3:0] erro_jogada,
    output logic [3:0] chaves,
    output logic       ocupado,
    output logic       fim_jogadas,
    output logic [3:0] db_rodada,
    output logic [3:0] db_jogada,
    output logic [3:0] db_estado
);

    localparam int TW = largura_timer(T_ESPERA, T_PRESS, T_SOLTA);
    localparam logic [TW-1:0] L_FIM_ESPERA = TW'(T_ESPERA - 1);
    localparam logic [TW-1:0] L_FIM_PRESS  = TW'(T_PRESS - 1);
    localparam logic [TW-1:0] L_FIM_SOLTA  = TW'(T_SOLTA - 1);
    localparam logic [3:0]    L_ULTIMA     = 4'(N_RODADAS - 1);

    estado_t       r_estado, w_prox;
    logic [3:0]    r_rodada, w_rodada_prox;
    logic [3:0]    r_jogada, w_jogada_prox;
    logic [TW-1:0] r_timer, w_timer_prox;
    logic          r_erro, w_erro_prox;
    logic [3:0]    w_rom_dado;

    rom_jogadas_16x4 u_rom (
        .i_endereco (r_jogada),
        .o_dado     (w_rom_dado)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= INICIAL;
            r_rodada <= '0;
            r_jogada <= '0;
            r_timer  <= '0;
            r_erro   <= 1'b0;
        end else begin
            r_estado <= w_prox;
            r_rodada <= w_rodada_prox;
            r_jogada <= w_jogada_prox;
            r_timer  <= w_timer_prox;
            r_erro   <= w_erro_prox;
        end
    end

    // The timer counts up from 0 in every phase and is cleared on each state
    // entry; a phase ends when the count reaches its length minus one.
    always_comb begin
        w_prox        = r_estado;
        w_rodada_prox = r_rodada;
        w_jogada_prox = r_jogada;
        w_timer_prox  = r_timer + TW'(1);
        case (r_estado)
            INICIAL, FIM: begin
                w_timer_prox = r_timer;
                if (iniciar) begin
                    w_prox        = ESPERA_RODADA;
                    w_rodada_prox = '0;
                    w_jogada_prox = '0;
                    w_timer_prox  = '0;
                end
            end
            ESPERA_RODADA: begin
                if (parar) begin
                    w_prox       = FIM;
                    w_timer_prox = r_timer;
                end else if (r_timer == L_FIM_ESPERA) begin
                    w_prox       = PRESSIONA;
                    w_timer_prox = '0;
                end
            end
            PRESSIONA: begin
                if (parar) begin
                    w_prox       = FIM;
                    w_timer_prox = r_timer;
                end else if (r_timer == L_FIM_PRESS) begin
                    w_prox       = SOLTA;
                    w_timer_prox = '0;
                end
            end
            SOLTA: begin
                if (parar) begin
                    w_prox       = FIM;
                    w_timer_prox = r_timer;
                end else if (r_timer == L_FIM_SOLTA) begin
                    w_timer_prox = '0;
                    if (r_jogada < r_rodada) begin
                        w_prox        = PRESSIONA;
                        w_jogada_prox = r_jogada + 4'd1;
                    end else if (r_rodada < L_ULTIMA) begin
                        w_prox        = ESPERA_RODADA;
                        w_rodada_prox = r_rodada + 4'd1;
                        w_jogada_prox = '0;
                    end else begin
                        w_prox = FIM;
                    end
                end
            end
            default: begin
                w_prox        = INICIAL;
                w_rodada_prox = '0;
                w_jogada_prox = '0;
                w_timer_prox  = '0;
            end
        endcase

        // Error decision is registered alongside the next indices so chaves
        // stays a decode of registers only.
        w_erro_prox = forca_erro && (w_prox == PRESSIONA) &&
                      (w_rodada_prox == erro_rodada) &&
                      (w_jogada_prox == erro_jogada);
    end

    always_comb begin
        chaves = '0;
        if (r_estado == PRESSIONA)
            chaves = r_erro ? {w_rom_dado[2:0], w_rom_dado[3]} : w_rom_dado;
    end

    assign ocupado     = (r_estado == ESPERA_RODADA) || (r_estado == PRESSIONA) ||
                         (r_estado == SOLTA);
    assign fim_jogadas = (r_estado == FIM);
    assign db_rodada   = r_rodada;
    assign db_jogada   = r_jogada;
    assign db_estado   = {1'b0, r_estado};

endmodule

// File: tb/tb_jogador_automatico.sv
module tb_jogador_automatico;

    localparam int TE = 5;
    localparam int TP = 5;
    localparam int TS = 5;
    localparam int NR = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       parar = 1'b0;
    logic       forca_erro = 1'b0;
    logic [3:0] erro_rodada = '0;
    logic [3:0] erro_jogada = '0;
    logic [3:0] chaves, db_rodada, db_jogada, db_estado;
    logic       ocupado, fim_jogadas;

    always #5 clock = ~clock;

    jogador_automatico #(
        .T_ESPERA  (TE),
        .T_PRESS   (TP),
        .T_SOLTA   (TS),
        .N_RODADAS (NR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .parar       (parar),
        .forca_erro  (forca_erro),
        .erro_rodada (erro_rodada),
        .erro_jogada (erro_jogada),
        .chaves      (chaves),
        .ocupado     (ocupado),
        .fim_jogadas (fim_jogadas),
        .db_rodada   (db_rodada),
        .db_jogada   (db_jogada),
        .db_estado   (db_estado)
    );

    logic [3:0] ROM_REF [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                                 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_cmp++;
        if (atual !== esperado) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
        end
    endtask

    // ---------------- reference model: per-cycle timeline of a game ----------------
    typedef struct {
        logic [3:0] ch;
        logic [3:0] ro;
        logic [3:0] jo;
        logic [3:0] st;
    } passo_t;

    passo_t tl[$];
    int     m_modo = 0;   // 0 idle, 1 playing, 2 finished
    int     m_k = 0;
    logic [3:0] exp_chaves = '0, exp_rodada = '0, exp_jogada = '0, exp_estado = '0;
    logic       exp_ocupado = 1'b0, exp_fim = 1'b0;

    task automatic empilha(input int n, input logic [3:0] ch, input int r, input int j, input logic [3:0] st);
        passo_t p;
        p.ch = ch;
        p.ro = 4'(r);
        p.jo = 4'(j);
        p.st = st;
        for (int i = 0; i < n; i++) tl.push_back(p);
    endtask

    task automatic construir(input logic fe, input logic [3:0] er, input logic [3:0] ej);
        logic [3:0] v;
        tl.delete();
        for (int r = 0; r < NR; r++) begin
            empilha(TE, 4'h0, r, 0, 4'd1);
            for (int j = 0; j <= r; j++) begin
                v = ROM_REF[j];
                if (fe && r == int'(er) && j == int'(ej)) v = {v[2:0], v[3]};
                empilha(TP, v, r, j, 4'd2);
                empilha(TS, 4'h0, r, j, 4'd3);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_modo = 0;
            end else begin
                if (m_modo == 1) begin
                    if (parar) m_modo = 2;
                    else begin
                        m_k++;
                        if (m_k >= tl.size()) begin
                            m_modo = 2;
                            m_k = tl.size() - 1;
                        end
                    end
                end else if (iniciar) begin
                    construir(forca_erro, erro_rodada, erro_jogada);
                    m_k = 0;
                    m_modo = 1;
                end
            end
            if (m_modo == 1) begin
                exp_chaves = tl[m_k].ch; exp_rodada = tl[m_k].ro; exp_jogada = tl[m_k].jo;
                exp_estado = tl[m_k].st; exp_ocupado = 1'b1; exp_fim = 1'b0;
            end else if (m_modo == 2) begin
                exp_chaves = '0; exp_rodada = tl[m_k].ro; exp_jogada = tl[m_k].jo;
                exp_estado = 4'd4; exp_ocupado = 1'b0; exp_fim = 1'b1;
            end else begin
                exp_chaves = '0; exp_rodada = '0; exp_jogada = '0;
                exp_estado = '0; exp_ocupado = 1'b0; exp_fim = 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (chk_on) begin
                chk("m_chaves", 32'(chaves), 32'(exp_chaves));
                chk("m_rodada", 32'(db_rodada), 32'(exp_rodada));
                chk("m_jogada", 32'(db_jogada), 32'(exp_jogada));
                chk("m_estado", 32'(db_estado), 32'(exp_estado));
                chk("m_ocupado", 32'(ocupado), 32'(exp_ocupado));
                chk("m_fim", 32'(fim_jogadas), 32'(exp_fim));
            end
        end
    end

    // ---------------- stimulus and literal checks ----------------
    logic [3:0] pulsos[$];

    task automatic pulso_iniciar();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    // Called at the first negedge after iniciar was sampled (cycle 0).
    task automatic checar_inicio(input string nome);
        for (int c = 0; c < 15; c++) begin
            chk({nome, "_chaves"}, 32'(chaves), (c >= 5 && c < 10) ? 32'd1 : 32'd0);
            @(negedge clock);
        end
        chk({nome, "_rodada1"}, 32'(db_rodada), 32'd1);
        chk({nome, "_estado1"}, 32'(db_estado), 32'd1);
    endtask

    task automatic rodar_jogo(input int c0, input int alvo, input bit ruido, output int dur);
        logic [3:0] ant;
        ant = chaves;
        dur = -1;
        pulsos.delete();
        for (int c = c0; c < c0 + 3000; c++) begin
            if (ruido) iniciar = (c == 300 || c == 700);
            if (fim_jogadas) begin
                dur = c;
                break;
            end
            if (int'(db_rodada) == alvo && chaves != 0 && ant == 0) pulsos.push_back(chaves);
            ant = chaves;
            @(negedge clock);
        end
        iniciar = 1'b0;
    endtask

    task automatic esperar_pressiona(input int rod);
        int n;
        n = 0;
        while (!(int'(db_rodada) == rod && chaves != 0) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("espera_pressiona_tempo", 32'(n < 2000), 32'd1);
    endtask

    initial begin
        int dur;
        int parada;
        @(posedge clock);
        chk_on = 1'b1;
        repeat (10) @(negedge clock);
        chk("reset_chaves", 32'(chaves), 32'd0);
        chk("reset_estado", 32'(db_estado), 32'd0);
        chk("reset_ocupado", 32'(ocupado), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // First game: startup timeline, full length, last-round order
        pulso_iniciar();
        checar_inicio("inicio");
        rodar_jogo(15, 15, 1'b0, dur);
        chk("duracao_jogo", 32'(dur), 32'd1440);
        chk("n_pulsos_r15", 32'(pulsos.size()), 32'd16);
        for (int i = 0; i < pulsos.size() && i < 16; i++)
            chk("pulso_r15", 32'(pulsos[i]), 32'(ROM_REF[i]));
        chk("fim_rodada", 32'(db_rodada), 32'd15);
        repeat (4) @(negedge clock);

        // Restart from FIM, with iniciar noise while busy
        pulso_iniciar();
        checar_inicio("reinicio");
        rodar_jogo(15, 15, 1'b1, dur);
        chk("duracao_ruido", 32'(dur), 32'd1440);

        // Error injection in round 2, play 1
        forca_erro = 1'b1; erro_rodada = 4'd2; erro_jogada = 4'd1;
        pulso_iniciar();
        rodar_jogo(0, 2, 1'b0, dur);
        chk("duracao_erro", 32'(dur), 32'd1440);
        chk("n_pulsos_r2", 32'(pulsos.size()), 32'd3);
        if (pulsos.size() == 3) begin
            chk("erro_p0", 32'(pulsos[0]), 32'd1);
            chk("erro_p1", 32'(pulsos[1]), 32'd4);
            chk("erro_p2", 32'(pulsos[2]), 32'd4);
        end
        forca_erro = 1'b0; erro_rodada = '0; erro_jogada = '0;

        // Abort during a press of round 3
        pulso_iniciar();
        esperar_pressiona(3);
        parar = 1'b1;
        @(negedge clock);
        parar = 1'b0;
        chk("parar_fim", 32'(fim_jogadas), 32'd1);
        chk("parar_chaves", 32'(chaves), 32'd0);
        chk("parar_rodada", 32'(db_rodada), 32'd3);
        chk("parar_estado", 32'(db_estado), 32'd4);
        repeat (5) @(negedge clock);
        chk("parar_retem_rodada", 32'(db_rodada), 32'd3);

        // Asynchronous reset between edges during a press
        pulso_iniciar();
        esperar_pressiona(1);
        #2 reset = 1'b1;
        #1;
        chk("async_chaves", 32'(chaves), 32'd0);
        chk("async_estado", 32'(db_estado), 32'd0);
        chk("async_rodada", 32'(db_rodada), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        pulso_iniciar();
        chk("async_reinicio_rodada", 32'(db_rodada), 32'd0);
        checar_inicio("pos_reset");

        // Randomised games with random abort points, noise and error settings
        for (int g = 0; g < 6; g++) begin
            @(negedge clock);
            forca_erro  = 1'($urandom_range(0, 1));
            erro_rodada = 4'($urandom_range(0, 7));
            erro_jogada = 4'($urandom_range(0, int'(erro_rodada)));
            parada      = $urandom_range(3, 700);
            pulso_iniciar();
            for (int c = 0; c < parada; c++) begin
                iniciar = ($urandom_range(0, 40) == 0);
                @(negedge clock);
            end
            iniciar = 1'b0;
            parar = 1'b1;
            @(negedge clock);
            repeat (8) begin
                parar = 1'($urandom_range(0, 1));
                @(negedge clock);
            end
            parar = 1'b0;
        end

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
